cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Control FSM for the 8-bit core: owns the single memory port and shares it between instruction fetch and LD/ST data access.
//  Fetches the instruction at pc and presents it to the decoder. Runs the data phase when the decoder flags a memory op, then advances pc.
//  Sits between memory, decoder and register file. Decoder is combinational off instr.
// PARAMETERS
//  PC_WIDTH   8    width of pc and mem_addr
//  RESET_PC   0    pc value loaded on reset
// PORTS
//  clk          in   1         single clock, all logic on posedge
//  reset        in   1         synchronous, active-high
//  run_en       in   1         1 = leave IDLE and execute; sampled only in IDLE
//  mem_req      out  1         memory access request
//  mem_we       out  1         1 = write (store), 0 = read
//  mem_addr     out  PC_WIDTH  access address
//  mem_wdata    out  8         store data
//  mem_ready    in   1         access complete (read data valid / write accepted)
//  mem_rdata    in   8         read data
//  instr        out  8         latched instruction, to decoder
//  instr_valid  out  1         1-cycle pulse: instr executes this cycle
//  is_mem_op    in   1         from decoder (LD/ST)
//  mem_rw       in   1         from decoder: 1 = ST, 0 = LD
//  data_addr    in   PC_WIDTH  LD/ST address from register file
//  store_data   in   8         ST data from register file
//  load_data    out  8         LD result
//  load_valid   out  1         1-cycle pulse: load_data valid, write to reg file
//  pc           out  PC_WIDTH  current program counter
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, instr=0, load_data=0; all strobes and mem_req=0. Reset wins over every other event.
//  States:
//   IDLE   mem_req=0. Goes to FETCH when run_en=1.
//   FETCH  mem_req=1, mem_we=0, mem_addr=pc.
//          On mem_ready: instr<=mem_rdata, go to EXEC.
//   EXEC   instr_valid=1 for exactly this cycle.
//          If is_mem_op: latch data_addr, store_data and mem_rw, then go to DATA.
//          Else: pc<=pc+1, go to FETCH.
//   DATA   mem_req=1, mem_we=latched mem_rw, mem_addr and mem_wdata from the latches.
//          On mem_ready: if load, load_data<=mem_rdata and load_valid=1 next cycle. pc<=pc+1, go to FETCH.
//  Outputs:
//   mem_req, mem_we, mem_addr, mem_wdata are registered/Moore.
//   They hold stable while mem_req=1 until mem_ready is sampled high.
//   When mem_req=0, mem_we=0 and mem_wdata=0.
//  Handshake:
//   mem_ready is ignored when mem_req=0.
//   Zero-wait memory (ready in the first req cycle) is legal.
//   Wait states are unbounded.
//  Latency (zero-wait memory):
//   Non-mem instr: 2 cycles (FETCH, EXEC).
//   LD/ST: 3 cycles (FETCH, EXEC, DATA). load_valid rises the cycle after the DATA handshake.
//  pc increments modulo 2^PC_WIDTH (0xFF -> 0x00 at width 8). No trap.
//  The pc increment for a mem op happens only on DATA completion; pc is constant throughout the op.
//  Decoder outputs are sampled only in EXEC.
//  Reset mid-access: mem_req drops the next cycle, the pending access is abandoned, and no load_valid is issued.
//  run_en=0 outside IDLE has no effect. No halt path; only reset returns the FSM to IDLE.
// TESTING
//  1. Reset, run_en=1, zero-wait memory with mem[0..2]={LI,INC,LI}:
//     -> fetch addrs 0,1,2 on consecutive 2-cycle slots; instr_valid pulses; pc ends at 3.
//  2. LD at pc=4, data_addr=0x20, mem[0x20]=0xA5:
//     -> DATA read at 0x20, load_data=0xA5, load_valid one cycle, next fetch addr 5.
//  3. ST at pc=6, data_addr=0x30, store_data=0x5C:
//     -> mem_we=1, mem_addr=0x30, mem_wdata=0x5C held until ready; no load_valid; pc=7.
//  4. 3 wait states on both FETCH and DATA for an LD:
//     -> addr/we stable for all 4 req cycles; one instr_valid; one load_valid.
//  5. pc=0xFF, non-mem instr -> next fetch at 0x00.
//  6. Assert reset during DATA wait state:
//     -> mem_req=0 next cycle, pc=RESET_PC, IDLE, no load_valid even if mem_ready then rises.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control FSM of the 8-bit core.
// Shares one memory port between instruction fetch and LD/ST data access.
module cpu_sequencer #(
    parameter int                     PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_en,
    output logic                mem_req,
    output logic                mem_we,
    output logic [PC_WIDTH-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic                mem_ready,
    input  logic [7:0]          mem_rdata,
    output logic [7:0]          instr,
    output logic                instr_valid,
    input  logic                is_mem_op,
    input  logic                mem_rw,
    input  logic [PC_WIDTH-1:0] data_addr,
    input  logic [7:0]          store_data,
    output logic [7:0]          load_data,
    output logic                load_valid,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_DATA  = 2'd3;

    logic [1:0]          state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [7:0]          instr_q;
    logic [7:0]          load_data_q;
    logic                load_valid_q;
    logic [PC_WIDTH-1:0] daddr_q;
    logic [7:0]          sdata_q;
    logic                rw_q;

    // Sequencer state, pc, instruction and data-phase latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 8'h00;
            load_data_q  <= 8'h00;
            load_valid_q <= 1'b0;
            daddr_q      <= '0;
            sdata_q      <= 8'h00;
            rw_q         <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (run_en) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        instr_q <= mem_rdata;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem_op) begin
                        daddr_q <= data_addr;
                        sdata_q <= store_data;
                        rw_q    <= mem_rw;
                        state_q <= S_DATA;
                    end else begin
                        pc_q    <= pc_q + PC_WIDTH'(1);
                        state_q <= S_FETCH;
                    end
                end
                S_DATA: begin
                    if (mem_ready) begin
                        if (!rw_q) begin
                            load_data_q  <= mem_rdata;
                            load_valid_q <= 1'b1;
                        end
                        pc_q    <= pc_q + PC_WIDTH'(1);
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory port is a pure function of registered state, so it stays
    // stable across wait states.
    always_comb begin
        mem_req   = (state_q == S_FETCH) || (state_q == S_DATA);
        mem_we    = (state_q == S_DATA) && rw_q;
        mem_addr  = (state_q == S_DATA) ? daddr_q : pc_q;
        mem_wdata = (state_q == S_DATA) ? sdata_q : 8'h00;
    end

    assign instr       = instr_q;
    assign instr_valid = (state_q == S_EXEC);
    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed vector table plus hand-written sequences
// for wait states, pc wrap and reset during a data access.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_en;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic [7:0] instr;
    logic       instr_valid;
    logic       is_mem_op;
    logic       mem_rw;
    logic [7:0] data_addr;
    logic [7:0] store_data;
    logic [7:0] load_data;
    logic       load_valid;
    logic [7:0] pc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .reset(reset), .run_en(run_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .instr(instr),
        .instr_valid(instr_valid), .is_mem_op(is_mem_op),
        .mem_rw(mem_rw), .data_addr(data_addr),
        .store_data(store_data), .load_data(load_data),
        .load_valid(load_valid), .pc(pc)
    );

    typedef struct {
        logic       rst, run, rdy;
        logic [7:0] rdata;
        logic       mop, rw;
        logic [7:0] da, sd;
        logic       req, we;
        logic [7:0] addr, wd;
        logic       iv, lv;
        logic [7:0] ld, pcx;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(
        input logic rst, run, rdy, input logic [7:0] rdata,
        input logic mop, rw, input logic [7:0] da, sd,
        input logic req, we, input logic [7:0] addr, wd,
        input logic iv, lv, input logic [7:0] ld, pcx);
        vec_t v;
        v.rst = rst; v.run = run; v.rdy = rdy; v.rdata = rdata;
        v.mop = mop; v.rw = rw; v.da = da; v.sd = sd;
        v.req = req; v.we = we; v.addr = addr; v.wd = wd;
        v.iv = iv; v.lv = lv; v.ld = ld; v.pcx = pcx;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic rdy, input logic [7:0] rdata,
                         input logic mop, rw,
                         input logic [7:0] da, sd);
        mem_ready  = rdy;
        mem_rdata  = rdata;
        is_mem_op  = mop;
        mem_rw     = rw;
        data_addr  = da;
        store_data = sd;
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        run_en = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

        //    rst run rdy rdata mop rw da sd | req we addr wd iv lv ld pc
        tbl[0]  = mk(0,1,0,8'h00,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,0,0,8'h00,8'h00);
        tbl[1]  = mk(0,0,1,8'h01,0,0,8'h00,8'h00, 1,0,8'h00,8'h00,0,0,8'h00,8'h00);
        tbl[2]  = mk(0,0,1,8'h00,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,1,0,8'h00,8'h00);
        tbl[3]  = mk(0,0,1,8'h02,0,0,8'h00,8'h00, 1,0,8'h01,8'h00,0,0,8'h00,8'h01);
        tbl[4]  = mk(0,0,0,8'h00,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,1,0,8'h00,8'h01);
        tbl[5]  = mk(0,0,1,8'h03,0,0,8'h00,8'h00, 1,0,8'h02,8'h00,0,0,8'h00,8'h02);
        tbl[6]  = mk(0,0,0,8'h00,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,1,0,8'h00,8'h02);
        tbl[7]  = mk(0,0,1,8'h04,0,0,8'h00,8'h00, 1,0,8'h03,8'h00,0,0,8'h00,8'h03);
        tbl[8]  = mk(0,0,0,8'h00,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,1,0,8'h00,8'h03);
        tbl[9]  = mk(0,0,1,8'h80,0,0,8'h00,8'h00, 1,0,8'h04,8'h00,0,0,8'h00,8'h04);
        tbl[10] = mk(0,0,0,8'h00,1,0,8'h20,8'h11, 0,0,8'h00,8'h00,1,0,8'h00,8'h04);
        tbl[11] = mk(0,0,1,8'hA5,0,0,8'h00,8'h00, 1,0,8'h20,8'h11,0,0,8'h00,8'h04);
        tbl[12] = mk(0,0,1,8'h05,0,0,8'h00,8'h00, 1,0,8'h05,8'h00,0,1,8'hA5,8'h05);
        tbl[13] = mk(0,0,0,8'h00,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,1,0,8'h00,8'h05);
        tbl[14] = mk(0,0,1,8'hC0,0,0,8'h00,8'h00, 1,0,8'h06,8'h00,0,0,8'h00,8'h06);
        tbl[15] = mk(0,0,0,8'h00,1,1,8'h30,8'h5C, 0,0,8'h00,8'h00,1,0,8'h00,8'h06);
        tbl[16] = mk(0,0,0,8'h00,0,0,8'h00,8'h00, 1,1,8'h30,8'h5C,0,0,8'h00,8'h06);
        tbl[17] = mk(0,0,1,8'h00,0,0,8'h00,8'h00, 1,1,8'h30,8'h5C,0,0,8'h00,8'h06);
        tbl[18] = mk(0,0,1,8'h06,0,0,8'h00,8'h00, 1,0,8'h07,8'h00,0,0,8'h00,8'h07);
        tbl[19] = mk(0,0,0,8'h00,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,1,0,8'h00,8'h07);
        tbl[20] = mk(0,0,0,8'h00,0,0,8'h00,8'h00, 1,0,8'h08,8'h00,0,0,8'h00,8'h08);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_iv", instr_valid, 0);
        chk("rst_lv", load_valid, 0);
        chk("rst_pc", pc, 0);
        chk("rst_instr", instr, 0);
        chk("rst_ld", load_data, 0);

        for (int i = 0; i < 21; i++) begin
            reset  = tbl[i].rst;
            run_en = tbl[i].run;
            drive(tbl[i].rdy, tbl[i].rdata, tbl[i].mop, tbl[i].rw,
                  tbl[i].da, tbl[i].sd);
            chk($sformatf("v%0d_req", i), mem_req, tbl[i].req);
            chk($sformatf("v%0d_we", i), mem_we, tbl[i].we);
            chk($sformatf("v%0d_wd", i), mem_wdata, tbl[i].wd);
            chk($sformatf("v%0d_iv", i), instr_valid, tbl[i].iv);
            chk($sformatf("v%0d_lv", i), load_valid, tbl[i].lv);
            chk($sformatf("v%0d_pc", i), pc, tbl[i].pcx);
            if (tbl[i].req)
                chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
            if (tbl[i].lv)
                chk($sformatf("v%0d_ld", i), load_data, tbl[i].ld);
            @(negedge clk);
        end

        // LD at pc 8, three wait states on fetch and on data
        for (int k = 0; k < 3; k++) begin
            chk("w_f_req", mem_req, 1);
            chk("w_f_addr", mem_addr, 8'h08);
            chk("w_f_we", mem_we, 0);
            chk("w_f_iv", instr_valid, 0);
            drive(k == 2, 8'h81, 1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge clk);
        end
        chk("w_exec_iv", instr_valid, 1);
        chk("w_exec_instr", instr, 8'h81);
        chk("w_exec_pc", pc, 8'h08);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 8'h77);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("w_d_req", mem_req, 1);
            chk("w_d_addr", mem_addr, 8'h40);
            chk("w_d_we", mem_we, 0);
            chk("w_d_wd", mem_wdata, 8'h77);
            chk("w_d_pc", pc, 8'h08);
            chk("w_d_iv", instr_valid, 0);
            chk("w_d_lv", load_valid, 0);
            drive(k == 3, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge clk);
        end
        chk("w_lv", load_valid, 1);
        chk("w_ld", load_data, 8'h3C);
        chk("w_next_addr", mem_addr, 8'h09);
        drive(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("w_lv_once", load_valid, 0);

        // run non-mem instructions up to pc 0xFF, then wrap
        found = 1'b0;
        for (int c = 0; c < 1000 && !found; c++) begin
            if (mem_req && mem_addr == 8'hFF) found = 1'b1;
            else @(negedge clk);
        end
        chk("wrap_reach_ff", found, 1);
        chk("wrap_pc_ff", pc, 8'hFF);
        @(negedge clk);
        chk("wrap_iv", instr_valid, 1);
        @(negedge clk);
        chk("wrap_req", mem_req, 1);
        chk("wrap_addr", mem_addr, 8'h00);
        chk("wrap_pc", pc, 8'h00);

        // reset during a data wait state at pc 1
        @(negedge clk);
        @(negedge clk);
        chk("r_fetch_pc", pc, 8'h01);
        drive(1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00);
        @(negedge clk);
        chk("r_data_req", mem_req, 1);
        chk("r_data_addr", mem_addr, 8'h50);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("r_req", mem_req, 0);
        chk("r_pc", pc, 8'h00);
        chk("r_lv", load_valid, 0);
        reset  = 1'b0;
        run_en = 1'b0;
        drive(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("r_idle_req", mem_req, 0);
            chk("r_idle_lv", load_valid, 0);
            chk("r_idle_iv", instr_valid, 0);
            chk("r_idle_ld", load_data, 8'h00);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
